// File: rtl/i2c_bus_conditioner_if.sv
// I2C pin-side bundle: raw pins in, conditioned levels, strobes and status out.
interface i2c_bus_conditioner_if;
  logic       scl_raw;
  logic       sda_raw;
  logic       scl_filt;
  logic       sda_filt;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       bus_busy;
  logic       timeout;
  logic [7:0] glitch_cnt;

  modport master (
    output scl_raw, sda_raw,
    input  scl_filt, sda_filt, scl_rise, scl_fall,
    input  start_det, stop_det, bus_busy, timeout, glitch_cnt
  );

  modport slave (
    input  scl_raw, sda_raw,
    output scl_filt, sda_filt, scl_rise, scl_fall,
    output start_det, stop_det, bus_busy, timeout, glitch_cnt
  );
endinterface

// File: rtl/i2c_bus_conditioner.sv
// I2C front-end: synchronizes and deglitches SCL/SDA, derives edge and START/STOP
// strobes, tracks bus ownership and forces idle on an SCL-low timeout.
module i2c_bus_conditioner #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  i2c_bus_conditioner_if.slave  bus
);

  localparam int unsigned FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   w_scl_s;
  logic                   w_sda_s;

  logic [FW-1:0]          r_scl_cnt;
  logic [FW-1:0]          r_sda_cnt;
  logic                   r_scl_filt;
  logic                   r_sda_filt;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl_glitch;
  logic                   w_sda_glitch;
  logic [8:0]             w_glitch_sum;
  logic [7:0]             r_glitch_cnt;

  logic [0:0]             r_state;
  logic [TW-1:0]          r_tcnt;
  logic [TW-1:0]          w_tcnt_next;
  logic                   w_start;
  logic                   w_stop;
  logic                   w_timeout;

  // Synchronizers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_raw};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_raw};
    end
  end

  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  // A disagreement that collapses before reaching FILTER_CYCLES samples is a glitch
  assign w_scl_glitch = (w_scl_s == r_scl_filt) && (r_scl_cnt != '0);
  assign w_sda_glitch = (w_sda_s == r_sda_filt) && (r_sda_cnt != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scl_filt <= 1'b1;
      r_scl_cnt  <= '0;
    end else if (w_scl_s == r_scl_filt) begin
      r_scl_cnt  <= '0;
    end else if (r_scl_cnt == FILT_LAST) begin
      r_scl_filt <= w_scl_s;
      r_scl_cnt  <= '0;
    end else begin
      r_scl_cnt  <= r_scl_cnt + FW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sda_filt <= 1'b1;
      r_sda_cnt  <= '0;
    end else if (w_sda_s == r_sda_filt) begin
      r_sda_cnt  <= '0;
    end else if (r_sda_cnt == FILT_LAST) begin
      r_sda_filt <= w_sda_s;
      r_sda_cnt  <= '0;
    end else begin
      r_sda_cnt  <= r_sda_cnt + FW'(1);
    end
  end

  assign w_glitch_sum = {1'b0, r_glitch_cnt} + 9'(w_scl_glitch) + 9'(w_sda_glitch);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch_sum[8]) begin
      r_glitch_cnt <= '1;
    end else begin
      r_glitch_cnt <= w_glitch_sum[7:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= r_scl_filt;
      r_sda_prev <= r_sda_filt;
    end
  end

  // SCL must be stable high across the SDA transition; a simultaneous SCL change disqualifies it
  assign w_start = r_sda_prev & ~r_sda_filt & r_scl_filt & r_scl_prev;
  assign w_stop  = ~r_sda_prev & r_sda_filt & r_scl_filt & r_scl_prev;

  assign w_tcnt_next = r_tcnt + TW'(1);
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_state == ST_BUSY) &&
                       !r_scl_filt && (w_tcnt_next == TO_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tcnt <= '0;
          if (w_start) begin
            r_state <= ST_BUSY;
          end
        end
        default: begin
          if (w_stop || w_timeout) begin
            r_state <= ST_IDLE;
            r_tcnt  <= '0;
          end else if (r_scl_filt) begin
            r_tcnt  <= '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_tcnt  <= w_tcnt_next;
          end
        end
      endcase
    end
  end

  assign bus.scl_filt   = r_scl_filt;
  assign bus.sda_filt   = r_sda_filt;
  assign bus.scl_rise   = r_scl_filt & ~r_scl_prev;
  assign bus.scl_fall   = ~r_scl_filt & r_scl_prev;
  assign bus.start_det  = w_start;
  assign bus.stop_det   = w_stop;
  assign bus.bus_busy   = (r_state == ST_BUSY);
  assign bus.timeout    = w_timeout;
  assign bus.glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Directed bench for i2c_bus_conditioner with default parameters.
module tb_i2c_bus_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   err = 0;

  i2c_bus_conditioner_if bus_if();

  i2c_bus_conditioner #(
    .SYNC_STAGES(2),
    .FILTER_CYCLES(3),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    bus_if.scl_raw = 1'b1;
    bus_if.sda_raw = 1'b1;
    rst = 1'b1;
    ticks(2);
    vec++;
    if ({bus_if.scl_filt, bus_if.sda_filt} !== 2'b11) begin
      err++; $display("FAIL reset_filt: got %b expected 11", {bus_if.scl_filt, bus_if.sda_filt});
    end
    vec++;
    if ({bus_if.scl_rise, bus_if.scl_fall, bus_if.start_det, bus_if.stop_det, bus_if.timeout, bus_if.bus_busy} !== 6'b0) begin
      err++; $display("FAIL reset_pulses: got %b expected 000000",
        {bus_if.scl_rise, bus_if.scl_fall, bus_if.start_det, bus_if.stop_det, bus_if.timeout, bus_if.bus_busy});
    end
    vec++;
    if (bus_if.glitch_cnt !== 8'd0) begin
      err++; $display("FAIL reset_glitch: got %0d expected 0", bus_if.glitch_cnt);
    end
    rst = 1'b0;
    ticks(8);
  endtask

  task automatic test_glitch();
    int nfall = 0;
    int nlow  = 0;
    int nrise = 0;
    int trise = 0;
    bus_if.scl_raw = 1'b0;
    ticks(2);
    bus_if.scl_raw = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (bus_if.scl_fall) nfall++;
      if (!bus_if.scl_filt) nlow++;
    end
    vec++;
    if (nfall != 0 || nlow != 0) begin
      err++; $display("FAIL glitch2_scl: fall=%0d low=%0d expected 0 0", nfall, nlow);
    end
    vec++;
    if (bus_if.glitch_cnt !== 8'd1) begin
      err++; $display("FAIL glitch2_cnt: got %0d expected 1", bus_if.glitch_cnt);
    end

    bus_if.scl_raw = 1'b0;
    bus_if.sda_raw = 1'b0;
    tick();
    bus_if.scl_raw = 1'b1;
    bus_if.sda_raw = 1'b1;
    ticks(8);
    vec++;
    if (bus_if.glitch_cnt !== 8'd3 || bus_if.start_det !== 1'b0 || bus_if.bus_busy !== 1'b0) begin
      err++; $display("FAIL glitch_both: cnt=%0d busy=%b expected 3 0", bus_if.glitch_cnt, bus_if.bus_busy);
    end

    bus_if.scl_raw = 1'b0;
    nlow = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 3) bus_if.scl_raw = 1'b1;
      if (t == 4) begin
        vec++;
        if (bus_if.scl_filt !== 1'b1 || bus_if.scl_fall !== 1'b0) begin
          err++; $display("FAIL fall_early: filt=%b fall=%b expected 1 0", bus_if.scl_filt, bus_if.scl_fall);
        end
      end
      if (t == 5) begin
        vec++;
        if (bus_if.scl_filt !== 1'b0 || bus_if.scl_fall !== 1'b1) begin
          err++; $display("FAIL fall_latency: filt=%b fall=%b expected 0 1", bus_if.scl_filt, bus_if.scl_fall);
        end
      end
      if (!bus_if.scl_filt) nlow++;
      if (bus_if.scl_rise) begin nrise++; trise = t; end
    end
    vec++;
    if (nlow != 3) begin
      err++; $display("FAIL filt_low_len: got %0d expected 3", nlow);
    end
    vec++;
    if (nrise != 1 || trise != 8) begin
      err++; $display("FAIL rise_time: count=%0d at=%0d expected 1 at 8", nrise, trise);
    end
    vec++;
    if (bus_if.glitch_cnt !== 8'd3) begin
      err++; $display("FAIL accept_no_glitch: got %0d expected 3", bus_if.glitch_cnt);
    end
  endtask

  task automatic test_start_stop();
    int nstart = 0;
    int nstop  = 0;
    bus_if.sda_raw = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (bus_if.start_det) nstart++;
      if (bus_if.stop_det) nstop++;
      if (t == 5) begin
        vec++;
        if (bus_if.start_det !== 1'b1 || bus_if.bus_busy !== 1'b0) begin
          err++; $display("FAIL start_pulse: start=%b busy=%b expected 1 0", bus_if.start_det, bus_if.bus_busy);
        end
      end
      if (t == 6) begin
        vec++;
        if (bus_if.bus_busy !== 1'b1) begin
          err++; $display("FAIL busy_rise: got %b expected 1", bus_if.bus_busy);
        end
      end
    end
    vec++;
    if (nstart != 1 || nstop != 0) begin
      err++; $display("FAIL start_count: start=%0d stop=%0d expected 1 0", nstart, nstop);
    end

    nstart = 0;
    bus_if.sda_raw = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (bus_if.start_det) nstart++;
      if (bus_if.stop_det) nstop++;
      if (t == 5) begin
        vec++;
        if (bus_if.stop_det !== 1'b1 || bus_if.bus_busy !== 1'b1) begin
          err++; $display("FAIL stop_pulse: stop=%b busy=%b expected 1 1", bus_if.stop_det, bus_if.bus_busy);
        end
      end
      if (t == 6) begin
        vec++;
        if (bus_if.bus_busy !== 1'b0) begin
          err++; $display("FAIL busy_fall: got %b expected 0", bus_if.bus_busy);
        end
      end
    end
    vec++;
    if (nstop != 1 || nstart != 0) begin
      err++; $display("FAIL stop_count: stop=%0d start=%0d expected 1 0", nstop, nstart);
    end
  endtask

  task automatic sample_clk(inout int nr, inout int nf, inout int ns, inout int np,
                            inout bit seen, inout int drops);
    tick();
    if (bus_if.scl_rise) nr++;
    if (bus_if.scl_fall) nf++;
    if (bus_if.start_det) ns++;
    if (bus_if.stop_det) np++;
    if (bus_if.bus_busy) seen = 1'b1;
    else if (seen) drops++;
  endtask

  task automatic test_back_to_back();
    int  nr = 0, nf = 0, ns = 0, np = 0, drops = 0;
    bit  seen = 1'b0;
    bus_if.sda_raw = 1'b0;
    for (int t = 0; t < 10; t++) sample_clk(nr, nf, ns, np, seen, drops);
    for (int k = 0; k < 8; k++) begin
      bus_if.scl_raw = 1'b0;
      for (int j = 0; j < 20; j++) begin
        if (k == 7 && j == 10) bus_if.sda_raw = 1'b1;
        sample_clk(nr, nf, ns, np, seen, drops);
      end
      bus_if.scl_raw = 1'b1;
      for (int j = 0; j < 20; j++) sample_clk(nr, nf, ns, np, seen, drops);
    end
    bus_if.sda_raw = 1'b0;
    for (int t = 0; t < 10; t++) sample_clk(nr, nf, ns, np, seen, drops);
    vec++;
    if (nr != 8 || nf != 8) begin
      err++; $display("FAIL scl_edges: rise=%0d fall=%0d expected 8 8", nr, nf);
    end
    vec++;
    if (ns != 2 || np != 0) begin
      err++; $display("FAIL rstart_count: start=%0d stop=%0d expected 2 0", ns, np);
    end
    vec++;
    if (!seen || drops != 0) begin
      err++; $display("FAIL busy_hold: seen=%0d drops=%0d expected 1 0", seen, drops);
    end
    bus_if.sda_raw = 1'b1;
    ticks(10);
    vec++;
    if (bus_if.bus_busy !== 1'b0) begin
      err++; $display("FAIL rstart_stop: busy=%b expected 0", bus_if.bus_busy);
    end
  endtask

  task automatic test_timeout();
    int nto = 0;
    int tto = 0;
    bus_if.sda_raw = 1'b0;
    ticks(10);
    bus_if.scl_raw = 1'b0;
    for (int t = 1; t <= 1010; t++) begin
      tick();
      if (bus_if.timeout) begin nto++; tto = t; end
      if (t == 1003) begin
        vec++;
        if (bus_if.bus_busy !== 1'b1) begin
          err++; $display("FAIL to_busy_before: got %b expected 1", bus_if.bus_busy);
        end
      end
      if (t == 1005) begin
        vec++;
        if (bus_if.bus_busy !== 1'b0) begin
          err++; $display("FAIL to_busy_after: got %b expected 0", bus_if.bus_busy);
        end
      end
    end
    vec++;
    if (nto != 1 || tto != 1004) begin
      err++; $display("FAIL timeout_pulse: count=%0d at=%0d expected 1 at 1004", nto, tto);
    end
    bus_if.scl_raw = 1'b1;
    ticks(10);
    bus_if.sda_raw = 1'b1;
    ticks(10);

    nto = 0;
    bus_if.sda_raw = 1'b0;
    ticks(10);
    bus_if.scl_raw = 1'b0;
    for (int t = 0; t < 999; t++) begin
      tick();
      if (bus_if.timeout) nto++;
    end
    bus_if.scl_raw = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (bus_if.timeout) nto++;
    end
    vec++;
    if (nto != 0 || bus_if.bus_busy !== 1'b1) begin
      err++; $display("FAIL no_timeout_999: count=%0d busy=%b expected 0 1", nto, bus_if.bus_busy);
    end
    bus_if.sda_raw = 1'b1;
    ticks(10);
  endtask

  task automatic test_reset_midbusy();
    bus_if.sda_raw = 1'b0;
    ticks(10);
    bus_if.scl_raw = 1'b0;
    ticks(7);
    vec++;
    if (bus_if.bus_busy !== 1'b1 || bus_if.scl_filt !== 1'b0) begin
      err++; $display("FAIL midbusy_setup: busy=%b scl=%b expected 1 0", bus_if.bus_busy, bus_if.scl_filt);
    end
    bus_if.scl_raw = 1'b1;
    bus_if.sda_raw = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    vec++;
    if ({bus_if.scl_filt, bus_if.sda_filt, bus_if.bus_busy, bus_if.glitch_cnt} !== {2'b11, 1'b0, 8'd0}) begin
      err++; $display("FAIL reset_async: filt=%b%b busy=%b glitch=%0d expected 11 0 0",
        bus_if.scl_filt, bus_if.sda_filt, bus_if.bus_busy, bus_if.glitch_cnt);
    end
    vec++;
    if ({bus_if.scl_rise, bus_if.scl_fall, bus_if.start_det, bus_if.stop_det, bus_if.timeout} !== 5'b0) begin
      err++; $display("FAIL reset_async_pulses: got %b expected 00000",
        {bus_if.scl_rise, bus_if.scl_fall, bus_if.start_det, bus_if.stop_det, bus_if.timeout});
    end
    tick();
    rst = 1'b0;
    ticks(10);
    vec++;
    if (bus_if.bus_busy !== 1'b0 || bus_if.scl_filt !== 1'b1 || bus_if.sda_filt !== 1'b1) begin
      err++; $display("FAIL post_reset_idle: busy=%b filt=%b%b expected 0 11",
        bus_if.bus_busy, bus_if.scl_filt, bus_if.sda_filt);
    end
  endtask

  task automatic test_glitch_saturate();
    int sda_moved = 0;
    int exp_cnt;
    for (int i = 1; i <= 300; i++) begin
      bus_if.sda_raw = 1'b0;
      tick();
      if (!bus_if.sda_filt) sda_moved++;
      bus_if.sda_raw = 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick();
        if (!bus_if.sda_filt) sda_moved++;
      end
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
        exp_cnt = (i > 255) ? 255 : i;
        vec++;
        if (bus_if.glitch_cnt !== 8'(exp_cnt)) begin
          err++; $display("FAIL glitch_sat_%0d: got %0d expected %0d", i, bus_if.glitch_cnt, exp_cnt);
        end
      end
    end
    vec++;
    if (sda_moved != 0 || bus_if.start_det !== 1'b0) begin
      err++; $display("FAIL sda_stable: low_cycles=%0d expected 0", sda_moved);
    end
  endtask

  initial begin
    bus_if.scl_raw = 1'b1;
    bus_if.sda_raw = 1'b1;
    test_reset();
    test_glitch();
    test_start_stop();
    test_back_to_back();
    test_timeout();
    test_reset_midbusy();
    test_glitch_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
